// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/status controller for an asynchronous FIFO: write address,
// Gray write pointer, synchronised read pointer, full/almost-full, level, overflow.
module wptr_full_ctrl #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = (1 << ADDRSIZE) - 2
) (
  input  logic                wr_clk,
  input  logic                wr_rst_n,
  input  logic                wr_req,
  input  logic [ADDRSIZE:0]   rd_ptr_gray,
  input  logic                ovf_clr,
  output logic                wr_en,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wr_level,
  output logic [ADDRSIZE:0]   wr_ptr_gray,
  output logic                wr_overflow
);

  localparam logic [ADDRSIZE:0] AFULL_TH = AFULL_LEVEL[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wgray_q, wgray_d;
  logic [ADDRSIZE:0] rq1_q, rq2_q;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_q, level_d;
  logic              wfull_q, wfull_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              push;

  assign push = wr_req & ~wfull_q;

  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(rq2_q >> i);
    end

    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, push};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    level_d = wbin_d - rbin;

    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    wfull_d = (wgray_d == {~rq2_q[ADDRSIZE:ADDRSIZE-1], rq2_q[ADDRSIZE-2:0]});
    afull_d = (level_d >= AFULL_TH);

    ovf_d = ovf_q;
    if (wr_req & wfull_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      level_q <= '0;
      wfull_q <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rd_ptr_gray;
      rq2_q   <= rq1_q;
      level_q <= level_d;
      wfull_q <= wfull_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_en        = push;
  assign wr_addr      = wbin_q[ADDRSIZE-1:0];
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wr_level     = level_q;
  assign wr_ptr_gray  = wgray_q;
  assign wr_overflow  = ovf_q;

endmodule
